// File: rtl/spi_driver_pkg.sv
// Shared types for the SPI master engine: FSM state encoding, host mode codes
// and small decode helpers.
package spi_driver_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_EN_SETUP = 4'd2,
    ST_SHIFT_LO = 4'd3,
    ST_SHIFT_HI = 4'd4,
    ST_EN_HOLD  = 4'd5,
    ST_DONE_RX  = 4'd6
  } state_t;

  localparam logic [1:0] RW_WRITE   = 2'b01;
  localparam logic [1:0] RW_READ    = 2'b10;
  localparam logic [4:0] FRAME_BITS = 5'd16;

  function automatic logic rw_valid(input logic [1:0] rw);
    return (rw == RW_WRITE) || (rw == RW_READ);
  endfunction

  // SPI_EN covers the setup guard, all shift phases and the hold guard
  function automatic logic en_active(input state_t st);
    logic act;
    case (st)
      ST_EN_SETUP, ST_SHIFT_LO, ST_SHIFT_HI, ST_EN_HOLD: act = 1'b1;
      default:                                          act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/spi_driver_clk_gen.sv
// Phase timer for the SPI engine: counts clk cycles in the current FSM phase
// and raises tick on the last cycle of a phase of length `period`.
module spi_driver_clk_gen #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic [CW-1:0] period,
  output logic          tick
);

  logic [CW-1:0] cnt_r;

  // Cycle counter within a phase, cleared whenever the FSM changes phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (restart) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == (period - {{(CW-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/spi_driver.sv
// Single-master 3-wire+EN SPI engine: host write/read commands serialised MSB first.
// Optional macro SPI_MISO_SYNC_EN adds a 2-flop MISO synchroniser (needs CLK_DIV >= 3).
module spi_driver
  import spi_driver_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int SETUP_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       command_read,
  input  logic [1:0] Spi_rw,
  input  logic       tx_read,
  input  logic [7:0] Spi_tx_reg,
  input  logic       rx_read,
  output logic [7:0] Spi_rx_reg,
  output logic       busy,
  output logic [3:0] cur_state,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CLK_LINE,
  output logic       SPI_EN
);

  localparam logic [7:0] DIV_P   = 8'(CLK_DIV);
  localparam logic [7:0] SETUP_P = 8'(SETUP_CYC);

  state_t      state_r, state_s;
  logic [1:0]  mode_r;
  logic [7:0]  slot0_r, slot1_r;
  logic [1:0]  ptr_r;
  logic [15:0] shift_r;
  logic [15:0] load_word_s;
  logic [4:0]  bit_cnt_r;
  logic [7:0]  rx_shift_r;
  logic [7:0]  period_s;
  logic        tick_s;
  logic        restart_s;
  logic        cap_s;
  logic        is_read_s;
  logic        read_data_s;
  logic        sample_s;
  logic        miso_s;
  logic        enter_setup_s;
  logic        enter_lo_s;

  assign is_read_s     = (mode_r == RW_READ);
  assign read_data_s   = is_read_s && (bit_cnt_r[4:3] == 2'b01);
  assign cap_s         = tx_read && ((state_r == ST_IDLE) || (state_r == ST_LOAD)) && (ptr_r != 2'd2);
  assign enter_setup_s = (state_r == ST_LOAD) && (state_s == ST_EN_SETUP);
  assign enter_lo_s    = (state_s == ST_SHIFT_LO) && (state_r != ST_SHIFT_LO);
  assign restart_s     = (state_s != state_r);
  assign load_word_s   = is_read_s ? {slot0_r, 8'h00} : {slot0_r, slot1_r};
  assign cur_state     = state_r;

  spi_driver_clk_gen #(.CW(8)) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_s),
    .period  (period_s),
    .tick    (tick_s)
  );

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_r;

  if (CLK_DIV < 3) begin : g_div_check
    $error("SPI_MISO_SYNC_EN requires CLK_DIV >= 3");
  end

  // Two-flop synchroniser for the asynchronous slave data line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_sync_r <= 2'b00;
    end else begin
      miso_sync_r <= {miso_sync_r[0], SPI_MISO};
    end
  end

  assign miso_s   = miso_sync_r[1];
  assign sample_s = (state_r == ST_SHIFT_HI) && tick_s && read_data_s;
`else
  assign miso_s   = SPI_MISO;
  assign sample_s = (state_s == ST_SHIFT_HI) && (state_r != ST_SHIFT_HI) && read_data_s;
`endif

  // Next-state decode and phase length selection
  always_comb begin
    state_s  = state_r;
    period_s = DIV_P;
    case (state_r)
      ST_IDLE: begin
        if (command_read && rw_valid(Spi_rw)) state_s = ST_LOAD;
        else                                  state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (is_read_s ? (ptr_r != 2'd0) : (ptr_r == 2'd2)) state_s = ST_EN_SETUP;
        else                                              state_s = ST_LOAD;
      end
      ST_EN_SETUP: begin
        period_s = SETUP_P;
        if (tick_s) state_s = ST_SHIFT_HI;
        else        state_s = ST_EN_SETUP;
      end
      ST_SHIFT_HI: begin
        if (tick_s) state_s = ST_SHIFT_LO;
        else        state_s = ST_SHIFT_HI;
      end
      ST_SHIFT_LO: begin
        if (tick_s && (bit_cnt_r == FRAME_BITS)) state_s = ST_EN_HOLD;
        else if (tick_s)                         state_s = ST_SHIFT_HI;
        else                                     state_s = ST_SHIFT_LO;
      end
      ST_EN_HOLD: begin
        period_s = SETUP_P;
        if (tick_s && is_read_s) state_s = ST_DONE_RX;
        else if (tick_s)         state_s = ST_IDLE;
        else                     state_s = ST_EN_HOLD;
      end
      ST_DONE_RX: begin
        if (rx_read) state_s = ST_IDLE;
        else         state_s = ST_DONE_RX;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Command mode latch and host byte capture into the two tx slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_r  <= 2'b00;
      slot0_r <= 8'h00;
      slot1_r <= 8'h00;
      ptr_r   <= 2'd0;
    end else begin
      if ((state_r == ST_IDLE) && (state_s == ST_LOAD)) mode_r <= Spi_rw;
      if (cap_s) begin
        if (ptr_r == 2'd0) slot0_r <= Spi_tx_reg;
        else               slot1_r <= Spi_tx_reg;
        ptr_r <= ptr_r + 2'd1;
      end else if ((state_r == ST_EN_HOLD) && tick_s) begin
        ptr_r <= 2'd0;
      end
    end
  end

  // MOSI shifter: MSB presented during setup, next bit on each SPI falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r   <= 16'h0000;
      SPI_MOSI  <= 1'b0;
      bit_cnt_r <= 5'd0;
    end else begin
      if (enter_setup_s) begin
        shift_r  <= load_word_s;
        SPI_MOSI <= load_word_s[15];
      end else if (enter_lo_s) begin
        shift_r  <= {shift_r[14:0], 1'b0};
        SPI_MOSI <= shift_r[14];
      end else if (state_s == ST_IDLE) begin
        SPI_MOSI <= 1'b0;
      end
      if (enter_setup_s)                          bit_cnt_r <= 5'd0;
      else if ((state_r == ST_SHIFT_HI) && tick_s) bit_cnt_r <= bit_cnt_r + 5'd1;
    end
  end

  // MISO capture during the data half of a read; result published at frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shift_r <= 8'h00;
      Spi_rx_reg <= 8'h00;
    end else begin
      if (sample_s) rx_shift_r <= {rx_shift_r[6:0], miso_s};
      if ((state_r == ST_EN_HOLD) && (state_s == ST_DONE_RX)) Spi_rx_reg <= rx_shift_r;
    end
  end

  // Registered bus and status outputs, decoded from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SPI_EN       <= 1'b0;
      SPI_CLK_LINE <= 1'b0;
      busy         <= 1'b0;
    end else begin
      SPI_EN       <= en_active(state_s);
      SPI_CLK_LINE <= (state_s == ST_SHIFT_HI);
      busy         <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spi_driver.sv
// Scoreboard bench for spi_driver: stimulus queues expected frames/read data,
// a bus monitor (also acting as the SPI slave) pops and compares them.
module tb_spi_driver;

  localparam int SETUP_CYC = 2;
`ifdef SPI_MISO_SYNC_EN
  localparam int CLK_DIV = 3;
`else
  localparam int CLK_DIV = 2;
`endif
  // command edge to SPI_EN fall: 2 LOAD cycles, setup, 32 half-periods, hold
  localparam int WR_LAT = 2 + SETUP_CYC + 32 * CLK_DIV + SETUP_CYC;

  logic       clk = 1'b0;
  logic       reset;
  logic       command_read;
  logic [1:0] spi_rw;
  logic       tx_read;
  logic [7:0] spi_tx_reg;
  logic       rx_read;
  logic [7:0] spi_rx_reg;
  logic       busy;
  logic [3:0] cur_state;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
  logic       spi_clk_line;
  logic       spi_en;

  spi_driver #(.CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .command_read (command_read),
    .Spi_rw       (spi_rw),
    .tx_read      (tx_read),
    .Spi_tx_reg   (spi_tx_reg),
    .rx_read      (rx_read),
    .Spi_rx_reg   (spi_rx_reg),
    .busy         (busy),
    .cur_state    (cur_state),
    .SPI_MOSI     (spi_mosi),
    .SPI_MISO     (spi_miso),
    .SPI_CLK_LINE (spi_clk_line),
    .SPI_EN       (spi_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    int          rises;
  } exp_t;

  exp_t       frame_q[$];
  logic [7:0] rx_q[$];
  int compared = 0;
  int mismatched = 0;
  int frames_pushed = 0;
  int frames_seen = 0;
  logic [7:0] slave_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bus monitor and slave model
  logic        prev_en = 1'b0;
  logic        prev_sclk = 1'b0;
  logic [3:0]  prev_state = 4'd0;
  logic [15:0] frame_bits = 16'h0000;
  int          rises = 0;
  int          low_cycles = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [7:0] rx_exp;
    if (spi_en && !prev_en) begin
      if (frames_seen > 0) check("en_gap", 32'(low_cycles >= 1), 32'd1);
      frame_bits = 16'h0000;
      rises = 0;
    end
    if (spi_en && spi_clk_line && !prev_sclk) begin
      frame_bits = {frame_bits[14:0], spi_mosi};
      rises++;
    end
    if (spi_en && !spi_clk_line && prev_sclk) begin
      if (rises >= 8 && rises < 16) spi_miso = slave_byte[3'(15 - rises)];
      else                          spi_miso = 1'($urandom);
    end
    if (!spi_en && prev_en) begin
      frames_seen++;
      if (frame_q.size() == 0) begin
        check("unexpected_frame", 32'(frame_q.size()), 32'd1);
      end else begin
        e = frame_q.pop_front();
        check("frame_bits", 32'(frame_bits), 32'(e.word));
        check("frame_rises", 32'(rises), 32'(e.rises));
      end
    end
    if (cur_state == 4'd6 && prev_state != 4'd6) begin
      if (rx_q.size() == 0) begin
        check("unexpected_rx", 32'(rx_q.size()), 32'd1);
      end else begin
        rx_exp = rx_q.pop_front();
        check("rx_data", 32'(spi_rx_reg), 32'(rx_exp));
      end
    end
    if (spi_en) low_cycles = 0;
    else        low_cycles++;
    prev_en    = spi_en;
    prev_sclk  = spi_clk_line;
    prev_state = cur_state;
  end

  task automatic start_cmd(input logic [1:0] rw, input logic [7:0] b0, input logic with_tx);
    command_read = 1'b1;
    spi_rw       = rw;
    tx_read      = with_tx;
    spi_tx_reg   = b0;
    @(negedge clk);
    command_read = 1'b0;
    tx_read      = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int poke_at);
    int   n;
    logic seen;
    frame_q.push_back('{word: {a, d}, rises: 16});
    frames_pushed++;
    start_cmd(2'b01, a, 1'b1);
    check("busy_after_cmd", 32'(busy), 32'd1);
    tx_read    = 1'b1;
    spi_tx_reg = d;
    @(negedge clk);
    tx_read = 1'b0;
    n = 2;
    seen = 1'b0;
    while (n < 400 && !(seen && !spi_en)) begin
      if (spi_en) seen = 1'b1;
      command_read = (n == poke_at);
      tx_read      = (n == poke_at);
      if (n == poke_at) begin
        spi_rw     = 2'b10;
        spi_tx_reg = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    command_read = 1'b0;
    tx_read      = 1'b0;
    check("write_latency", 32'(n - 1), 32'(WR_LAT));
    check("busy_after_write", 32'(busy), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] s);
    int n;
    slave_byte = s;
    frame_q.push_back('{word: {a, 8'h00}, rises: 16});
    frames_pushed++;
    rx_q.push_back(s);
    start_cmd(2'b10, a, 1'b1);
    check("busy_after_rd_cmd", 32'(busy), 32'd1);
    n = 0;
    while (cur_state !== 4'd6 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("read_reach_done", 32'(cur_state), 32'd6);
    repeat (3) @(negedge clk);
    check("done_rx_hold", 32'(cur_state), 32'd6);
    check("done_rx_busy", 32'(busy), 32'd1);
    check("rx_reg_hold", 32'(spi_rx_reg), 32'(s));
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("idle_after_ack", 32'(cur_state), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int   r;
    int   n;
    logic ps;
    logic saw;
    reset        = 1'b1;
    command_read = 1'b0;
    spi_rw       = 2'b00;
    tx_read      = 1'b0;
    spi_tx_reg   = 8'h00;
    rx_read      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(cur_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(spi_en), 32'd0);
    check("rst_sclk", 32'(spi_clk_line), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx", 32'(spi_rx_reg), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_write(8'h9E, 8'h3C, 0);
    do_read(8'h85, 8'hA5);

    // no-op mode codes must never start a frame
    for (int k = 0; k < 2; k++) begin
      saw = 1'b0;
      start_cmd((k == 0) ? 2'b00 : 2'b11, 8'h00, 1'b0);
      repeat (10) begin
        saw = saw | busy | spi_en;
        @(negedge clk);
      end
      check("noop_ignored", 32'(saw), 32'd0);
    end

    do_write(8'h5A, 8'hC3, 20);

    // asynchronous reset after the 8th SPI rising edge of a write
    frame_q.push_back('{word: {8'h00, 8'h71}, rises: 8});
    frames_pushed++;
    start_cmd(2'b01, 8'h71, 1'b1);
    tx_read    = 1'b1;
    spi_tx_reg = 8'hE8;
    @(negedge clk);
    tx_read = 1'b0;
    r = 0; n = 0; ps = 1'b0;
    while (r < 8 && n < 400) begin
      @(negedge clk);
      n++;
      if (spi_clk_line && !ps) r++;
      ps = spi_clk_line;
    end
    check("abort_reached_bit7", 32'(r), 32'd8);
    #1 reset = 1'b1;
    #1;
    check("abort_en", 32'(spi_en), 32'd0);
    check("abort_sclk", 32'(spi_clk_line), 32'd0);
    check("abort_state", 32'(cur_state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx", 32'(spi_rx_reg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_write(8'hF0, 8'h0F, 0);
    do_read(8'h81, 8'h96);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 0) do_write(8'($urandom), 8'($urandom), 0);
      else                           do_read(8'($urandom), 8'($urandom));
    end

    repeat (20) @(negedge clk);
    check("frames_seen", 32'(frames_seen), 32'(frames_pushed));
    check("frame_q_drained", 32'(frame_q.size()), 32'd0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
